way_alloc_ctrl: RTL and testbench

WAY_ALLOC_CTRL -- requirements
Module: way_alloc_ctrl

---
 rtl/way_alloc_ctrl_pkg.sv | 26 ++
 rtl/way_alloc_ctrl_way_select.sv | 51 +++++
 rtl/way_alloc_ctrl.sv | 156 +++++++++++++++
 tb/tb_way_alloc_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/way_alloc_ctrl_pkg.sv
// Shared definitions for the way allocation controller: default geometry,
// FSM state encoding and the true-LRU age update rule.
package way_alloc_ctrl_pkg;

    localparam int WAYS_DEF    = 8;
    localparam int WAY_W_DEF   = 3;
    localparam int INDEX_W_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WB     = 2'd2,
        ST_GRANT  = 2'd3
    } state_t;

    // New age of one way when sel_age's way becomes MRU: the touched way goes
    // to 0 and every way younger than it ages by one, keeping a permutation.
    function automatic int unsigned age_next(input int unsigned age,
                                             input int unsigned sel_age,
                                             input logic        is_sel);
        if (is_sel) return 0;
        if (age < sel_age) return age + 1;
        return age;
    endfunction

endpackage

// File: rtl/way_alloc_ctrl_way_select.sv
// Combinational way choice for one set: hit way, else lowest invalid way,
// else the LRU way (age WAYS-1), which is flagged as an eviction.
module way_select
    import way_alloc_ctrl_pkg::*;
#(
    parameter int WAYS  = WAYS_DEF,
    parameter int WAY_W = WAY_W_DEF
) (
    input  logic [WAYS-1:0]            i_valid,
    input  logic [WAYS-1:0][WAY_W-1:0] i_age,
    input  logic                       i_hit,
    input  logic [WAY_W-1:0]           i_hit_way,
    output logic [WAY_W-1:0]           o_way,
    output logic                       o_evict
);

    logic             w_found_inv;
    logic [WAY_W-1:0] w_inv_way;
    logic [WAY_W-1:0] w_lru_way;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_found_inv = 1'b0;
        w_inv_way   = '0;
        w_lru_way   = '0;
        // Descending scan so the lowest-numbered invalid way is the last write.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!i_valid[w]) begin
                w_found_inv = 1'b1;
                w_inv_way   = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (i_age[w] == WAY_W'(WAYS - 1)) w_lru_way = WAY_W'(w);
        end
    end

    always_comb begin
        o_way   = w_lru_way;
        o_evict = 1'b0;
        if (i_hit) begin
            o_way = i_hit_way;
        end else if (w_found_inv) begin
            o_way = w_inv_way;
        end else begin
            o_way   = w_lru_way;
            o_evict = 1'b1;
        end
    end

endmodule

// File: rtl/way_alloc_ctrl.sv
// Cache way allocator with per-set valid/dirty/true-LRU state and snoop invalidate.
// Define EVICT_WB_EN to add the dirty-victim writeback handshake (WB state).
module way_alloc_ctrl
    import way_alloc_ctrl_pkg::*;
#(
    parameter int WAYS    = WAYS_DEF,
    parameter int WAY_W   = WAY_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [INDEX_W-1:0] req_index,
    input  logic               req_hit,
    input  logic [WAY_W-1:0]   req_way,
    input  logic               req_write,
    output logic               grant_valid,
    output logic [WAY_W-1:0]   grant_way,
    output logic               grant_evict,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [INDEX_W-1:0] wb_index,
    output logic [WAY_W-1:0]   wb_way,
    input  logic               inval_valid,
    input  logic [INDEX_W-1:0] inval_index,
    input  logic [WAY_W-1:0]   inval_way
);

    localparam int SETS = 1 << INDEX_W;

    state_t r_state;
    state_t w_state_next;

    logic [INDEX_W-1:0] r_index;
    logic               r_hit;
    logic [WAY_W-1:0]   r_req_way;
    logic               r_write;
    logic [WAY_W-1:0]   r_sel_way;
    logic               r_evict;

    logic [SETS-1:0][WAYS-1:0]             r_valid;
    logic [SETS-1:0][WAYS-1:0]             r_dirty;
    logic [SETS-1:0][WAYS-1:0][WAY_W-1:0]  r_age;

    logic [WAY_W-1:0] w_sel_way;
    logic             w_sel_evict;
    logic             w_to_wb;
    logic             w_accept;

    way_select #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_way_select (
        .i_valid   (r_valid[r_index]),
        .i_age     (r_age[r_index]),
        .i_hit     (r_hit),
        .i_hit_way (r_req_way),
        .o_way     (w_sel_way),
        .o_evict   (w_sel_evict)
    );

    assign w_accept = req_valid && (r_state == ST_IDLE);

`ifdef EVICT_WB_EN
    assign w_to_wb  = w_sel_evict && r_dirty[r_index][w_sel_way];
    assign wb_valid = (r_state == ST_WB);
`else
    logic w_unused;
    assign w_to_wb  = 1'b0;
    assign wb_valid = 1'b0;
    assign w_unused = wb_ready;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_state_next = ST_LOOKUP;
            ST_LOOKUP: w_state_next = w_to_wb ? ST_WB : ST_GRANT;
`ifdef EVICT_WB_EN
            ST_WB:     if (wb_ready) w_state_next = ST_GRANT;
`endif
            ST_GRANT:  w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign grant_valid = (r_state == ST_GRANT);
    assign grant_way   = r_sel_way;
    assign grant_evict = grant_valid && r_evict;
    assign wb_index    = r_index;
    assign wb_way      = r_sel_way;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index   <= '0;
            r_hit     <= 1'b0;
            r_req_way <= '0;
            r_write   <= 1'b0;
            r_sel_way <= '0;
            r_evict   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_index   <= req_index;
                r_hit     <= req_hit;
                r_req_way <= req_way;
                r_write   <= req_write;
            end
            // Decision is frozen here so WB and GRANT see a stable victim.
            if (r_state == ST_LOOKUP) begin
                r_sel_way <= w_sel_way;
                r_evict   <= w_sel_evict;
            end
        end
    end

    // NOTE: the per-set state array is reset in full because valid bits and the LRU permutation must be defined after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            if (inval_valid) begin
                r_valid[inval_index][inval_way] <= 1'b0;
                r_dirty[inval_index][inval_way] <= 1'b0;
            end
            // Placed after the invalidate so a same-way grant update wins.
            if (r_state == ST_GRANT) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_age[r_index][w] <= WAY_W'(age_next(32'(r_age[r_index][w]),
                                                         32'(r_age[r_index][r_sel_way]),
                                                         WAY_W'(w) == r_sel_way));
                end
                if (!r_hit) begin
                    r_valid[r_index][r_sel_way] <= 1'b1;
                    r_dirty[r_index][r_sel_way] <= r_write;
                end else begin
                    r_dirty[r_index][r_sel_way] <= r_dirty[r_index][r_sel_way] | r_write;
                end
            end
        end
    end

endmodule

// File: tb/tb_way_alloc_ctrl.sv
// Self-checking bench for way_alloc_ctrl: directed scenarios plus random traffic
// against a recency-list model; follows EVICT_WB_EN like the design.
module tb_way_alloc_ctrl;

    localparam int WAYS    = 8;
    localparam int WAY_W   = 3;
    localparam int INDEX_W = 6;
    localparam int SETS    = 64;
`ifdef EVICT_WB_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [INDEX_W-1:0] req_index;
    logic               req_hit;
    logic [WAY_W-1:0]   req_way;
    logic               req_write;
    logic               grant_valid;
    logic [WAY_W-1:0]   grant_way;
    logic               grant_evict;
    logic               wb_valid;
    logic               wb_ready;
    logic [INDEX_W-1:0] wb_index;
    logic [WAY_W-1:0]   wb_way;
    logic               inval_valid;
    logic [INDEX_W-1:0] inval_index;
    logic [WAY_W-1:0]   inval_way;

    always #5 clk = ~clk;

    way_alloc_ctrl #(
        .WAYS    (WAYS),
        .WAY_W   (WAY_W),
        .INDEX_W (INDEX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_index   (req_index),
        .req_hit     (req_hit),
        .req_way     (req_way),
        .req_write   (req_write),
        .grant_valid (grant_valid),
        .grant_way   (grant_way),
        .grant_evict (grant_evict),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_index    (wb_index),
        .wb_way      (wb_way),
        .inval_valid (inval_valid),
        .inval_index (inval_index),
        .inval_way   (inval_way)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: valid/dirty flags and a recency list per set (position 0 = MRU).
    bit mv  [SETS][WAYS];
    bit md  [SETS][WAYS];
    int ord [SETS][WAYS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                mv[s][w]  = 1'b0;
                md[s][w]  = 1'b0;
                ord[s][w] = w;
            end
        end
    endtask

    task automatic model_touch(input int s, input int w);
        int p;
        p = 0;
        for (int i = 0; i < WAYS; i++) if (ord[s][i] == w) p = i;
        for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
        ord[s][0] = w;
    endtask

    task automatic do_inval(input int s, input int w);
        @(negedge clk);
        inval_valid = 1'b1;
        inval_index = s[INDEX_W-1:0];
        inval_way   = w[WAY_W-1:0];
        @(posedge clk);
        #1;
        inval_valid = 1'b0;
        mv[s][w] = 1'b0;
        md[s][w] = 1'b0;
    endtask

    task automatic do_req(input int s, input bit hit, input int hw, input bit wr,
                          input int wb_delay, input bit inval_at_grant,
                          output int got_way, output bit got_evict);
        int exp_way;
        bit exp_evict;
        bit exp_wb;
        int cycles;
        int wb_cycles;
        bit seen;
        exp_evict = 1'b0;
        if (hit) begin
            exp_way = hw;
        end else begin
            exp_way = -1;
            for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) exp_way = w;
            if (exp_way < 0) begin
                exp_way   = ord[s][WAYS-1];
                exp_evict = 1'b1;
            end
        end
        exp_wb = WB_EN && exp_evict && md[s][exp_way];

        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_index = s[INDEX_W-1:0];
        req_hit   = hit;
        req_way   = hw[WAY_W-1:0];
        req_write = wr;
        cycles    = 0;
        wb_cycles = 0;
        seen      = 1'b0;
        while (!seen && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            req_valid = 1'b0;
            if (wb_valid) begin
                wb_cycles++;
                if (wb_cycles == 1) begin
                    check("wb_index", 32'(wb_index), 32'(s));
                    check("wb_way", 32'(wb_way), 32'(exp_way));
                end
                wb_ready = (wb_cycles > wb_delay);
            end
            if (grant_valid) seen = 1'b1;
        end
        wb_ready = 1'b0;
        check("grant_seen", 32'(seen), 1);
        got_way   = int'(grant_way);
        got_evict = grant_evict;
        check("grant_way", 32'(grant_way), 32'(exp_way));
        check("grant_evict", 32'(grant_evict), 32'(exp_evict));
        check("grant_latency", 32'(cycles), exp_wb ? 32'(3 + wb_delay) : 32'd2);
        check("wb_cycles", 32'(wb_cycles), exp_wb ? 32'(wb_delay + 1) : 32'd0);
        if (inval_at_grant) begin
            inval_valid = 1'b1;
            inval_index = s[INDEX_W-1:0];
            inval_way   = exp_way[WAY_W-1:0];
        end
        @(posedge clk);
        #1;
        inval_valid = 1'b0;
        check("grant_one_cycle", 32'(grant_valid), 0);
        check("req_ready_back", 32'(req_ready), 1);
        if (inval_at_grant) begin
            mv[s][exp_way] = 1'b0;
            md[s][exp_way] = 1'b0;
        end
        model_touch(s, exp_way);
        if (!hit) begin
            mv[s][exp_way] = 1'b1;
            md[s][exp_way] = wr;
        end else begin
            md[s][exp_way] = md[s][exp_way] | wr;
        end
    endtask

    initial begin
        int gw;
        bit ge;
        bit gseen;
        int vw[$];
        int s;
        int hw;
        bit hit;

        rst         = 1'b1;
        req_valid   = 1'b0;
        req_index   = '0;
        req_hit     = 1'b0;
        req_way     = '0;
        req_write   = 1'b0;
        wb_ready    = 1'b0;
        inval_valid = 1'b0;
        inval_index = '0;
        inval_way   = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_grant_valid", 32'(grant_valid), 0);
        check("rst_grant_evict", 32'(grant_evict), 0);
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_grant_way", 32'(grant_way), 0);
        check("rst_wb_way", 32'(wb_way), 0);
        check("rst_wb_index", 32'(wb_index), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 1);

        // Cold fills of set 0 take ways in ascending order.
        for (int i = 0; i < WAYS; i++) begin
            do_req(0, 1'b0, 0, 1'b0, 0, 1'b0, gw, ge);
            check("fill0_way", 32'(gw), 32'(i));
        end
        do_req(0, 1'b0, 0, 1'b0, 0, 1'b0, gw, ge);
        check("evict0_way", 32'(gw), 0);
        check("evict0_flag", 32'(ge), 1);
        do_req(0, 1'b1, 3, 1'b0, 0, 1'b0, gw, ge);
        check("hit0_way", 32'(gw), 3);
        do_req(0, 1'b0, 0, 1'b0, 0, 1'b0, gw, ge);
        check("lru_after_hit", 32'(gw), 1);

        // Invalidated hole in a full set is reused without eviction.
        for (int i = 0; i < WAYS; i++) do_req(2, 1'b0, 0, 1'b0, 0, 1'b0, gw, ge);
        do_inval(2, 6);
        do_req(2, 1'b0, 0, 1'b0, 0, 1'b0, gw, ge);
        check("inval_hole_way", 32'(gw), 6);
        check("inval_hole_evict", 32'(ge), 0);

        // Invalidate landing on the grant edge loses to the grant.
        do_req(1, 1'b0, 0, 1'b0, 0, 1'b0, gw, ge);
        do_req(1, 1'b0, 0, 1'b0, 0, 1'b0, gw, ge);
        do_req(1, 1'b0, 0, 1'b0, 0, 1'b1, gw, ge);
        check("same_edge_way", 32'(gw), 2);
        do_req(1, 1'b0, 0, 1'b0, 0, 1'b0, gw, ge);
        check("same_edge_kept", 32'(gw), 3);

        // Dirty victim: writeback with a slow acceptor when enabled.
        for (int i = 0; i < WAYS; i++) do_req(5, 1'b0, 0, 1'b1, 0, 1'b0, gw, ge);
        do_req(5, 1'b0, 0, 1'b0, 4, 1'b0, gw, ge);
        check("dirty_victim_way", 32'(gw), 0);
        check("dirty_victim_evict", 32'(ge), 1);

        // Reset in the middle of a request (WB state when enabled).
        @(negedge clk);
        req_valid = 1'b1;
        req_index = 6'd5;
        req_hit   = 1'b0;
        req_write = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
`ifdef EVICT_WB_EN
        @(posedge clk);
        #1;
        check("wb_before_rst", 32'(wb_valid), 1);
`endif
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_grant", 32'(grant_valid), 0);
        check("async_rst_wb", 32'(wb_valid), 0);
        check("async_rst_wb_index", 32'(wb_index), 0);
        check("async_rst_wb_way", 32'(wb_way), 0);
        check("async_rst_grant_way", 32'(grant_way), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        gseen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (grant_valid || wb_valid) gseen = 1'b1;
        end
        check("no_grant_after_rst", 32'(gseen), 0);
        check("ready_after_rst", 32'(req_ready), 1);

        // Random traffic over a few sets with interleaved invalidates.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0:       s = 0;
                1:       s = 1;
                2:       s = 5;
                default: s = 63;
            endcase
            if ($urandom_range(0, 3) == 0) do_inval(s, int'($urandom_range(0, WAYS - 1)));
            vw.delete();
            for (int w = 0; w < WAYS; w++) if (mv[s][w]) vw.push_back(w);
            hit = (vw.size() > 0) && ($urandom_range(0, 1) == 1);
            hw  = hit ? vw[$urandom_range(0, vw.size() - 1)] : int'($urandom_range(0, WAYS - 1));
            wb_ready = ($urandom_range(0, 1) == 1);
            do_req(s, hit, hw, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)), 1'b0, gw, ge);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
